// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction memory for riscv_cpu with a byte-stream loader.
// Answers the core's combinational fetch from an internal word array, fills the
// array from a little-endian byte stream, and holds the core in reset outside RUN.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   inst_addr_i       - fetch byte address from the core
//   inst_o            - fetched instruction (combinational)
//   fetch_err_o       - misaligned / out-of-range fetch in RUN (combinational)
//   run_i             - leave HALT without loading
//   load_start_i      - begin a load at word 0 (len sampled from load_len_i, 0 = full depth)
//   load_byte_i/valid - load data stream
//   load_ready_o      - stream accepted (high throughout LOAD)
//   load_done_o       - one-cycle pulse after the last word is written
//   load_words_o      - words written in the current or last load
//   core_rst_n_o      - active-low core reset, high only in RUN
module inst_rom_loader #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           inst_addr_i,
    output logic [31:0]           inst_o,
    output logic                  fetch_err_o,
    input  logic                  run_i,
    input  logic                  load_start_i,
    input  logic [DEPTH_LOG2-1:0] load_len_i,
    input  logic [7:0]            load_byte_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    output logic                  load_done_o,
    output logic [DEPTH_LOG2:0]   load_words_o,
    output logic                  core_rst_n_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           mem [DEPTH];
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      words_inc;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [1:0]            byte_cnt_q;
    logic [23:0]           byte_buf_q;
    logic                  accept;
    logic                  wr_en;
    logic                  done_d;
    logic                  load_enter;
    logic                  addr_ok;

    // Next-state and load-control decode
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        wr_en     = 1'b0;
        done_d    = 1'b0;
        words_inc = load_words_o + CNT_W'(1);
        case (state_q)
            ST_HALT: begin
                if (load_start_i) begin
                    state_d = ST_LOAD;
                end else if (run_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                accept = load_valid_i & load_ready_o;
                if (accept && (byte_cnt_q == 2'd3)) begin
                    wr_en = 1'b1;
                    if (words_inc == len_q) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (load_start_i) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_HALT;
        endcase
        load_enter = (state_q != ST_LOAD) && (state_d == ST_LOAD);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HALT;
            core_rst_n_o <= 1'b0;
            load_ready_o <= 1'b0;
            load_done_o  <= 1'b0;
            load_words_o <= '0;
            len_q        <= '0;
            wr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            byte_buf_q   <= '0;
        end else begin
            state_q      <= state_d;
            core_rst_n_o <= (state_d == ST_RUN);
            load_ready_o <= (state_d == ST_LOAD);
            load_done_o  <= done_d;
            if (load_enter) begin
                wr_ptr_q     <= '0;
                byte_cnt_q   <= '0;
                load_words_o <= '0;
                len_q        <= (load_len_i == '0) ? CNT_W'(DEPTH) : CNT_W'(load_len_i);
            end else if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                // Shift right so the first byte ends in [7:0] after three bytes
                byte_buf_q <= {load_byte_i, byte_buf_q[23:8]};
                if (wr_en) begin
                    wr_ptr_q     <= wr_ptr_q + DEPTH_LOG2'(1);
                    load_words_o <= words_inc;
                end
            end
        end
    end

    // Word array: not reset, a reset in the write cycle discards the partial word
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q] <= {load_byte_i, byte_buf_q};
        end
    end

    // Combinational fetch, only readable in RUN
    always_comb begin
        inst_o      = NOP_INST;
        fetch_err_o = 1'b0;
        addr_ok     = (inst_addr_i[1:0] == 2'b00) &&
                      ((inst_addr_i >> (DEPTH_LOG2 + 2)) == 32'd0);
        if (state_q == ST_RUN) begin
            if (addr_ok) begin
                inst_o = mem[inst_addr_i[DEPTH_LOG2+1:2]];
            end else begin
                fetch_err_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Testbench for inst_rom_loader (DEPTH_LOG2=4): directed scenarios plus a
// randomized phase, checked every cycle against a behavioural model.
module tb_inst_rom_loader;

    localparam int unsigned D = 4;
    localparam int unsigned N = 16;
    localparam int M_HALT = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   inst_addr_i;
    logic [31:0]   inst_o;
    logic          fetch_err_o;
    logic          run_i;
    logic          load_start_i;
    logic [D-1:0]  load_len_i;
    logic [7:0]    load_byte_i;
    logic          load_valid_i;
    logic          load_ready_o;
    logic          load_done_o;
    logic [D:0]    load_words_o;
    logic          core_rst_n_o;

    always #5 clk = ~clk;

    inst_rom_loader #(.DEPTH_LOG2(D), .NOP_INST(32'h0000_0013)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_addr_i  (inst_addr_i),
        .inst_o       (inst_o),
        .fetch_err_o  (fetch_err_o),
        .run_i        (run_i),
        .load_start_i (load_start_i),
        .load_len_i   (load_len_i),
        .load_byte_i  (load_byte_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_done_o  (load_done_o),
        .load_words_o (load_words_o),
        .core_rst_n_o (core_rst_n_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode  = M_HALT;
    bit          m_live  = 1'b0;
    bit          m_done  = 1'b0;
    int          m_words = 0;
    int          m_len   = 0;
    logic [31:0] m_mem   [N];
    bit          m_known [N];
    int unsigned m_bq    [$];
    int          dut_done_cnt = 0;

    function automatic void model_start();
        m_mode  = M_LOAD;
        m_words = 0;
        m_len   = (load_len_i == '0) ? int'(N) : int'(load_len_i);
        m_bq.delete();
    endfunction

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_live  = 1'b1;
            m_mode  = M_HALT;
            m_words = 0;
            m_bq.delete();
        end else if (m_live) begin
            case (m_mode)
                M_HALT: begin
                    if (load_start_i) model_start();
                    else if (run_i) m_mode = M_RUN;
                end
                M_LOAD: begin
                    if (load_valid_i) begin
                        m_bq.push_back(int'(load_byte_i));
                        if (m_bq.size() == 4) begin
                            m_mem[m_words]   = 32'(m_bq[0] + m_bq[1] * 256 + m_bq[2] * 65536 +
                                                   m_bq[3] * 16777216);
                            m_known[m_words] = 1'b1;
                            m_words++;
                            m_bq.delete();
                            if (m_words == m_len) begin
                                m_mode = M_RUN;
                                m_done = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (load_start_i) model_start();
                end
            endcase
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("core_rst_n", 32'(core_rst_n_o), 32'(m_mode == M_RUN));
            chk("load_ready", 32'(load_ready_o), 32'(m_mode == M_LOAD));
            chk("load_done", 32'(load_done_o), 32'(m_done));
            chk("load_words", 32'(load_words_o), 32'(m_words));
            if (m_mode == M_RUN) begin
                if ((inst_addr_i % 4 == 0) && ((inst_addr_i / 4) < N)) begin
                    chk("fetch_err_ok", 32'(fetch_err_o), 32'd0);
                    if (m_known[inst_addr_i / 4])
                        chk("fetch_data", inst_o, m_mem[inst_addr_i / 4]);
                end else begin
                    chk("fetch_err_bad", 32'(fetch_err_o), 32'd1);
                    chk("fetch_nop_bad", inst_o, 32'h13);
                end
            end else begin
                chk("idle_err", 32'(fetch_err_o), 32'd0);
                chk("idle_nop", inst_o, 32'h13);
            end
            if (load_done_o) dut_done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] prog2 [8] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    logic [7:0] part6 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int unsigned maxgap);
        repeat ($urandom_range(maxgap, 0)) tick();
        load_valid_i = 1'b1;
        load_byte_i  = b;
        tick();
        load_valid_i = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        inst_addr_i = a;
        tick();
    endtask

    initial begin
        int  acc;
        bit  got_done;
        rst          = 1'b1;
        inst_addr_i  = '0;
        run_i        = 1'b0;
        load_start_i = 1'b0;
        load_len_i   = '0;
        load_byte_i  = '0;
        load_valid_i = 1'b0;
        for (int i = 0; i < int'(N); i++) m_known[i] = 1'b0;

        // Reset hold
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_core_rst_n", 32'(core_rst_n_o), 32'd0);
        chk("rst_inst", inst_o, 32'h13);
        chk("rst_ready", 32'(load_ready_o), 32'd0);
        chk("rst_words", 32'(load_words_o), 32'd0);

        // Start beats run in HALT; full-depth load (len 0)
        run_i = 1'b1; load_start_i = 1'b1; load_len_i = '0;
        tick();
        run_i = 1'b0; load_start_i = 1'b0;
        chk("prio_ready", 32'(load_ready_o), 32'd1);
        chk("prio_core_rst_n", 32'(core_rst_n_o), 32'd0);
        dut_done_cnt = 0;
        acc = 0;
        got_done = 1'b0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            repeat ($urandom_range(2, 0)) tick();
            load_valid_i = 1'b1;
            load_byte_i  = 8'($urandom);
            if (load_ready_o) acc++;
            tick();
            load_valid_i = 1'b0;
            if (load_done_o) got_done = 1'b1;
        end
        chk("full_done_seen", 32'(got_done), 32'd1);
        chk("full_bytes", 32'(acc), 32'd64);
        chk("full_words", 32'(load_words_o), 32'd16);
        repeat (3) tick();
        chk("full_done_pulses", 32'(dut_done_cnt), 32'd1);

        // Fetch boundaries in RUN
        fetch(32'h2);
        chk("misalign_inst", inst_o, 32'h13);
        chk("misalign_err", 32'(fetch_err_o), 32'd1);
        fetch(32'h40);
        chk("oob_err", 32'(fetch_err_o), 32'd1);
        fetch(32'h3C);
        chk("last_err", 32'(fetch_err_o), 32'd0);
        chk("last_inst", inst_o, m_mem[15]);

        // Reload of 2 words from RUN with gaps
        inst_addr_i = 32'h0;
        load_start_i = 1'b1; load_len_i = D'(2);
        tick();
        load_start_i = 1'b0;
        chk("reload_core_rst_n", 32'(core_rst_n_o), 32'd0);
        chk("reload_inst", inst_o, 32'h13);
        for (int i = 0; i < 8; i++) send(prog2[i], 3);
        chk("two_done", 32'(load_done_o), 32'd1);
        chk("two_core_rst_n", 32'(core_rst_n_o), 32'd1);
        chk("two_ready", 32'(load_ready_o), 32'd0);
        chk("two_words", 32'(load_words_o), 32'd2);
        tick();
        chk("two_done_clear", 32'(load_done_o), 32'd0);
        fetch(32'h0);
        chk("two_word0", inst_o, 32'h0010_0093);
        fetch(32'h4);
        chk("two_word1", inst_o, 32'h0020_0113);

        // Reset in the middle of a 4-word load
        load_start_i = 1'b1; load_len_i = D'(4);
        tick();
        load_start_i = 1'b0;
        for (int i = 0; i < 6; i++) send(part6[i], 2);
        chk("mid_words_before", 32'(load_words_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_words", 32'(load_words_o), 32'd0);
        chk("mid_core_rst_n", 32'(core_rst_n_o), 32'd0);
        chk("mid_ready", 32'(load_ready_o), 32'd0);
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
        chk("mid_run", 32'(core_rst_n_o), 32'd1);
        fetch(32'h0);
        chk("mid_word0", inst_o, 32'hDDCC_BBAA);
        fetch(32'h4);
        chk("mid_word1_old", inst_o, 32'h0020_0113);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom_range(299, 0) == 0);
            load_start_i = ($urandom_range(39, 0) == 0);
            run_i        = ($urandom_range(9, 0) == 0);
            load_len_i   = D'($urandom);
            load_valid_i = 1'($urandom_range(1, 0));
            load_byte_i  = 8'($urandom);
            case ($urandom_range(3, 0))
                0: inst_addr_i = 32'($urandom_range(N - 1, 0)) << 2;
                1: inst_addr_i = $urandom;
                2: inst_addr_i = (32'($urandom_range(N - 1, 0)) << 2) | 32'($urandom_range(3, 1));
                default: inst_addr_i = 32'(N * 4) + (32'($urandom_range(15, 0)) << 2);
            endcase
            tick();
        end
        rst = 1'b0; load_start_i = 1'b0; run_i = 1'b0; load_valid_i = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory responder for `riscv_cpu`. It answers the core's combinational fetch (`inst_addr_o` → `inst_i`) from an internal word array. It also loads that array from a byte stream and holds the core in reset through a boot/reload sequence. It sits beside `riscv_cpu` at SoC top: fetch port to the core, load port to the host/UART bridge, and `core_rst_n_o` driving the core's `rst_n`.

## Interface
- `DEPTH_LOG2`, default 10: the array holds 2^DEPTH_LOG2 32-bit words.
- `NOP_INST`, default 32'h0000_0013: instruction returned whenever the array is not readable (`addi x0,x0,0`).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `inst_addr_i` in 32: fetch byte address from the core.
- `inst_o` out 32: fetched instruction (combinational).
- `fetch_err_o` out 1: fetch address misaligned or out of range (combinational, RUN only).
- `run_i` in 1: release the core from HALT without loading.
- `load_start_i` in 1: pulse; begin loading at word 0.
- `load_len_i` in DEPTH_LOG2: word count, sampled with `load_start_i`; 0 means 2^DEPTH_LOG2.
- `load_byte_i` in 8: load data byte.
- `load_valid_i` in 1: `load_byte_i` is valid.
- `load_ready_o` out 1: block accepts a byte.
- `load_done_o` out 1: one-cycle pulse when the last word is written.
- `load_words_o` out DEPTH_LOG2+1: words written in the current or last load.
- `core_rst_n_o` out 1: active-low reset to the core; high only in RUN.

## Operation
- The FSM has three states: HALT, LOAD and RUN. `rst` forces HALT.
- **HALT**
  - If `load_start_i`=1, go to LOAD. `load_start_i` has priority over `run_i`.
  - Else if `run_i`=1, go to RUN.
- **LOAD**
  - On entry: `wr_ptr`=0, `byte_cnt`=0, `load_words_o`=0, and `len`=`load_len_i` (0 maps to 2^DEPTH_LOG2).
  - A byte is accepted on a cycle with `load_valid_i & load_ready_o`. `load_ready_o`=1 throughout LOAD; there is no backpressure.
  - Bytes assemble little-endian: the first byte goes to [7:0], the fourth byte to [31:24].
  - On the 4th byte: write `mem[wr_ptr]` with `{byte,b2,b1,b0}`, then increment `wr_ptr` and `load_words_o`.
  - When the write makes `load_words_o`=`len`: go to RUN and pulse `load_done_o` in the following cycle.
  - `load_start_i` and `run_i` are ignored during LOAD.
- **RUN**
  - If `load_start_i`=1, go to LOAD (reload; the core is held again).
  - `run_i` is ignored.
- **Fetch**
  - In RUN with `inst_addr_i[1:0]`=0 and `inst_addr_i[31:2]` < 2^DEPTH_LOG2: `inst_o` = `mem[inst_addr_i[DEPTH_LOG2+1:2]]` and `fetch_err_o`=0.
  - In RUN with any other address: `inst_o`=`NOP_INST` and `fetch_err_o`=1.
  - In HALT or LOAD: `inst_o`=`NOP_INST` and `fetch_err_o`=0.
- **Memory**
  - The array is not reset. Contents survive `rst` and are only changed by LOAD writes.
  - Words at or beyond `len` keep their old contents.
- **Reset during LOAD**
  - Go to HALT and discard the partial word.
  - Words already written stay in the array.
  - `load_words_o` clears to 0.

## Timing
- Reset values:
  - state = HALT
  - `core_rst_n_o`=0, `load_ready_o`=0, `load_done_o`=0
  - `load_words_o`=0
  - `inst_o`=`NOP_INST`, `fetch_err_o`=0
- `core_rst_n_o`, `load_ready_o`, `load_done_o` and `load_words_o` are registered. They change the cycle after the triggering edge.
- Load timing:
  - The `load_start_i` at edge N gives `load_ready_o`=1 from cycle N+1.
  - The first byte can be accepted at edge N+1.
- Write timing:
  - The 4th byte accepted at edge M makes the word visible to fetch from cycle M+1.
  - The same edge M updates `load_words_o` and, for the final word, the state.
- Finishing a load: the final byte at edge M gives, in cycle M+1:
  - `load_done_o`=1 for exactly one cycle
  - `core_rst_n_o`=1
  - `load_ready_o`=0
- Reload from RUN: `load_start_i` at edge N gives `core_rst_n_o`=0 in cycle N+1.
- Fetch latency is 0 cycles (combinational), which matches the core's same-cycle `inst_i` use.
- Write-after-read in the same cycle is impossible, because fetch returns `NOP_INST` outside RUN.

## Test plan
- **Reset hold:** assert `rst` 2 cycles, then release → `core_rst_n_o`=0, `inst_o`=32'h13 and `load_ready_o`=0 until a start.
- **Load of 2 words:** `load_start_i` with `load_len_i`=2, then bytes 93,00,10,00,13,01,20,00 streamed with `load_valid_i` gaps → the last-byte edge is followed by `load_done_o` for 1 cycle and `load_words_o`=2. Expected results:
  - `core_rst_n_o`=1
  - address 0 reads 32'h0010_0093
  - address 4 reads 32'h0020_0113
- **Fetch errors in RUN:**
  - address 0x2 → `inst_o`=32'h13, `fetch_err_o`=1
  - address 0x1000 with DEPTH_LOG2=10 → `fetch_err_o`=1
  - address 0xFFC → `mem[1023]`, `fetch_err_o`=0
- **Reset mid-load:** `load_len_i`=4; assert `rst` after 6 bytes → HALT with `load_words_o`=0. Then `run_i` → word 0 holds the new value and word 1 holds its old contents.
- **Full depth and priority:**
  - `load_len_i`=0 with DEPTH_LOG2=4 → exactly 64 bytes accepted; `load_words_o`=16; `load_done_o` pulses once.
  - In HALT, `run_i`=1 and `load_start_i`=1 in the same cycle → LOAD is entered.
- **Reload:** in RUN, pulse `load_start_i` → `core_rst_n_o` drops next cycle, `inst_o`=32'h13 during the load, and new contents are fetched after `load_done_o`.
